serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder. Processes one bit per clock, LSB first, through a single full-adder cell plus a registered carry.
- Sits directly downstream of the full-adder cell (fa_v1), which it instantiates and sequences. It turns the combinational 1-bit stage into a multi-bit datapath block with a start/done handshake.
- Intended as the area-minimal adder option for the datapath practicals.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting start edge
- b  input  WIDTH  operand B; captured on the accepting start edge
- c_in  input  1  carry-in; captured on the accepting start edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result; holds until next completion
- c_out  output  1  registered final carry; holds with sum

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-operation):
  - state=IDLE, busy=0, done=0, sum=0, c_out=0.
  - Shift registers, carry register and bit counter cleared.
  - Any in-flight addition is abandoned.
- States: IDLE, RUN, DONE, encoded in 2 bits.
- IDLE:
  - busy=0, done=0.
  - On a clk edge with start=1: load a_sr<=a, b_sr<=b, carry<=c_in, cnt<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Every edge: the fa_v1 instance computes (s,co) from (a_sr[0], b_sr[0], carry).
  - On the same edge: a_sr>>=1, b_sr>>=1, res_sr<={s, res_sr[WIDTH-1:1]}, carry<=co, cnt<=cnt+1.
  - When cnt==WIDTH-1 on an edge, that edge processes the final (MSB) bit. It also loads sum<={s, res_sr[WIDTH-1:1]}, c_out<=co, and goes to DONE.
  - start is ignored in RUN; operands and outputs are unaffected.
- DONE:
  - done=1, busy=0 for exactly one cycle, then unconditionally return to IDLE.
  - start is ignored in DONE.
- Latency:
  - The accepting start edge is E0.
  - done is high in the cycle after edge E(WIDTH), i.e. WIDTH cycles after acceptance.
  - Minimum start-to-start period: WIDTH+2 cycles.
- Holding start high continuously re-triggers each time IDLE is reached, giving back-to-back operations with period WIDTH+2.
- sum/c_out change only on the completing edge. They keep the previous result through IDLE and the following RUN.
- Arithmetic: {c_out,sum} = a + b + c_in, exact, modulo 2^(WIDTH+1). No overflow flag; c_out serves as unsigned overflow.
- Counter width is $clog2(WIDTH). cnt never wraps inside RUN because the exit at WIDTH-1 is forced.
- Outputs busy and done decode from the state register only. No combinational path from inputs to outputs.

Decomposition:
- Package serial_adder_pkg holds:
  - typedef state_t (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - localparam DEFAULT_WIDTH=8
- Sub-module: exactly one instance of the existing fa_v1, port order (sum, c_out, a, b, c_in). No other submodules; the FSM, shift registers and counter are in serial_adder.

Test Plan:
- WIDTH=8; reset, then start with a=0x00, b=0x00, c_in=0 -> done pulses 8 cycles after acceptance; sum=0x00, c_out=0; busy high exactly 8 cycles.
- a=0x3C, b=0x0F, c_in=0 -> sum=0x4B, c_out=0. Then a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Then a=0xA5, b=0x5A, c_in=1 -> sum=0x00, c_out=1.
- Start a=0x10, b=0x20; pulse start again 3 cycles later with a=0xFF, b=0xFF -> second request ignored; result sum=0x30, c_out=0; done is a single 1-cycle pulse.
- Start a=0x77, b=0x11; drop reset_n for one cycle at cycle 4 of RUN -> outputs immediately 0, busy=0, no done pulse. Next start a=0x01, b=0x02 -> sum=0x03.
- Hold start=1 constantly with a=0x80, b=0x80, c_in=0 -> done every 10 cycles; sum=0x00, c_out=1 each time; sum stable between pulses.
- Randomised check against the reference model {c_out,sum}==a+b+c_in, 200 vectors, WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_v1.sv
// One-bit full-adder cell; the per-bit stage of the serial adder.
// Latency: purely combinational.
// Backpressure: none.
module fa_v1 (
  output logic sum,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus a carry flop.
// Latency: done pulses WIDTH cycles after the accepting start edge; period WIDTH+2.
// Backpressure: start is only sampled in IDLE; requests while busy/done are dropped.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;

  logic fa_s;
  logic fa_co;

  // The single adder cell always looks at the current LSBs and the running carry.
  fa_v1 u_fa (
    .sum   (fa_s),
    .c_out (fa_co),
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c_in  (carry_q)
  );

  // Next-state and datapath: load in IDLE, shift one bit per cycle in RUN, publish on the last bit.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        // Exit is forced on the MSB, so the counter never has to wrap inside RUN.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, res_sr_q[WIDTH-1:1]};
          c_out_d = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any addition in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
    end
  end

  // Status decodes straight from the state register; no input-to-output paths.
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_adder;

  logic clk;
  logic reset_n;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int total;
  int bad;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .a(a16), .b(b16), .c_in(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .c_out(cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete addition on the selected instance; returns result, latency, busy cycles, done length.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic cin,
                        output logic [31:0] s, output logic co, output int lat,
                        output int nbusy, output int dlen);
    logic bz, dn;
    s = '0; co = 1'b0; lat = -1; nbusy = 0; dlen = 0;
    @(negedge clk);
    if (w == 8) begin
      start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin;
    end else begin
      start16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; cin16 = cin;
    end
    @(posedge clk);
    for (int k = 0; k < w + 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start8 = 1'b0; start16 = 1'b0;
      end
      bz = (w == 8) ? busy8 : busy16;
      dn = (w == 8) ? done8 : done16;
      if (dn) begin
        lat = k;
        break;
      end
      if (bz) nbusy++;
    end
    if (lat >= 0) begin
      s  = (w == 8) ? {24'h0, sum8} : {16'h0, sum16};
      co = (w == 8) ? cout8 : cout16;
      dlen = 1;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        dn = (w == 8) ? done8 : done16;
        if (dn) dlen++;
        else break;
      end
    end
  endtask

  initial begin
    logic [31:0] s, ra, rb, mask;
    logic [32:0] tot;
    logic        co, rc;
    int          lat, nbusy, dlen, dcount, bcount, np, last_p;

    total = 0; bad = 0;
    reset_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start16 = 0; a16 = 0; b16 = 0; cin16 = 0;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl[4] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tbl[6] = '{8'hFE, 8'hFF, 1'b1, 8'hFE, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy8", {31'h0, busy8}, 0);
    chk("rst_done8", {31'h0, done8}, 0);
    chk("rst_sum8", {24'h0, sum8}, 0);
    chk("rst_cout8", {31'h0, cout8}, 0);
    chk("rst_busy16", {31'h0, busy16}, 0);
    chk("rst_sum16", {16'h0, sum16}, 0);
    reset_n = 1'b1;

    // Directed vector table
    foreach (tbl[i]) begin
      run_op(8, {24'h0, tbl[i].a}, {24'h0, tbl[i].b}, tbl[i].cin, s, co, lat, nbusy, dlen);
      chk($sformatf("tbl%0d_sum", i), s, {24'h0, tbl[i].s});
      chk($sformatf("tbl%0d_cout", i), {31'h0, co}, {31'h0, tbl[i].co});
      chk($sformatf("tbl%0d_lat", i), lat, 8);
      chk($sformatf("tbl%0d_busy", i), nbusy, 8);
      chk($sformatf("tbl%0d_dlen", i), dlen, 1);
    end

    // A second start during RUN must be ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(posedge clk);
    lat = -1; dcount = 0; s = '0; co = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) start8 = 1'b0;
      if (k == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end
      if (k == 4) start8 = 1'b0;
      if (done8) begin
        dcount++;
        if (lat < 0) begin
          lat = k; s = {24'h0, sum8}; co = cout8;
        end
      end
    end
    chk("ign_lat", lat, 8);
    chk("ign_dcount", dcount, 1);
    chk("ign_sum", s, 32'h30);
    chk("ign_cout", {31'h0, co}, 0);

    // Reset in the middle of RUN abandons the operation
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) start8 = 1'b0;
    end
    chk("mid_busy_before", {31'h0, busy8}, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, busy8}, 0);
    chk("mid_rst_done", {31'h0, done8}, 0);
    chk("mid_rst_sum", {24'h0, sum8}, 0);
    chk("mid_rst_cout", {31'h0, cout8}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dcount = 0; bcount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8) dcount++;
      if (busy8) bcount++;
    end
    chk("mid_no_done", dcount, 0);
    chk("mid_no_busy", bcount, 0);
    run_op(8, 32'h01, 32'h02, 1'b0, s, co, lat, nbusy, dlen);
    chk("post_rst_sum", s, 32'h03);
    chk("post_rst_cout", {31'h0, co}, 0);
    chk("post_rst_lat", lat, 8);

    // Start held high: back-to-back operations
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    np = 0; last_p = -1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done8) begin
        chk($sformatf("b2b_sum_p%0d", np), {24'h0, sum8}, 0);
        chk($sformatf("b2b_cout_p%0d", np), {31'h0, cout8}, 1);
        if (last_p >= 0) chk($sformatf("b2b_gap_p%0d", np), k - last_p, 10);
        last_p = k;
        np++;
      end else if (np > 0) begin
        chk($sformatf("b2b_hold_k%0d", k), {23'h0, cout8, sum8}, 32'h100);
      end
    end
    chk("b2b_pulses", np, 4);
    start8 = 1'b0;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy8 && !done8) begin
        lat = k;
        break;
      end
    end
    chk("b2b_drain", {31'h0, lat >= 0}, 1);

    // Randomised against arithmetic reference
    for (int wi = 0; wi < 2; wi++) begin
      int w;
      w = (wi == 0) ? 8 : 16;
      mask = (w == 8) ? 32'hFF : 32'hFFFF;
      for (int i = 0; i < 200; i++) begin
        ra = $urandom() & mask;
        rb = $urandom() & mask;
        rc = 1'($urandom_range(1, 0));
        tot = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
        run_op(w, ra, rb, rc, s, co, lat, nbusy, dlen);
        chk($sformatf("rnd%0d_%0d_sum", w, i), s, tot[31:0] & mask);
        chk($sformatf("rnd%0d_%0d_cout", w, i), {31'h0, co}, {31'h0, tot[w]});
        chk($sformatf("rnd%0d_%0d_lat", w, i), lat, w);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
